// File: rtl/aibnd_red_shift_seq_pkg.sv
// Shared types and constants for the AIB redundancy-shift sequencer.
package aibnd_red_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GATE,
      ST_APPLY,
      ST_RELEASE,
      ST_ACK
   } red_state_t;

   localparam int RED_CNT_W = 8;

   // Width needed to hold a lane index 0..n, where n itself means "no repair".
   function automatic int red_idx_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/aibnd_red_shift_seq_if.sv
// Configuration request / lane-mux control bundle for aibnd_red_shift_seq.
interface aibnd_red_shift_seq_if
   import aibnd_red_pkg::*;
#(
   parameter int NUM_LANES = 16,
   parameter int IDX_W     = red_idx_w(NUM_LANES)
);
   logic                 cfg_req;
   logic [IDX_W-1:0]     cfg_fail_idx;
   logic                 cfg_jtag_sel;
   logic                 cfg_ack;
   logic                 busy;
   logic                 mux_gate;
   logic [NUM_LANES-1:0] shift_en;
   logic                 jtag_clksel;
   logic                 err;
   logic [RED_CNT_W-1:0] repair_cnt;

   // Requester side: repair/configuration registers.
   modport master (
      output cfg_req, cfg_fail_idx, cfg_jtag_sel,
      input  cfg_ack, busy, mux_gate, shift_en, jtag_clksel, err, repair_cnt
   );

   // Sequencer side.
   modport slave (
      input  cfg_req, cfg_fail_idx, cfg_jtag_sel,
      output cfg_ack, busy, mux_gate, shift_en, jtag_clksel, err, repair_cnt
   );
endinterface

// File: rtl/aibnd_red_therm_dec.sv
// Lane index -> thermometer select: bit i set when lane i sits at or above the failed lane.
module aibnd_red_therm_dec
   import aibnd_red_pkg::*;
#(
   parameter int NUM_LANES = 16,
   parameter int IDX_W     = red_idx_w(NUM_LANES)
) (
   input  logic [IDX_W-1:0]     idx,
   output logic [NUM_LANES-1:0] therm
);
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Unsigned compare at IDX_W bits; idx==NUM_LANES leaves every lane unshifted.
      assign therm[gi] = (IDX_W'(gi) >= idx);
   end
endmodule

// File: rtl/aibnd_red_shift_seq.sv
// Redundancy-shift sequencer: gates the lane muxes, settles, applies the new
// shift_en / jtag_clksel pattern, settles again and releases the gate.
// Optional feature macro: AIBND_RED_REPAIR_CNT_EN (saturating applied-change counter).
module aibnd_red_shift_seq
   import aibnd_red_pkg::*;
#(
   parameter int NUM_LANES  = 16,
   parameter int SETTLE_CYC = 4,
   parameter int IDX_W      = red_idx_w(NUM_LANES)
) (
   input  logic                clk,
   input  logic                rst,
   aibnd_red_shift_seq_if.slave bus
);
   localparam int               CNT_W    = $clog2(SETTLE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

   red_state_t           state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     lat_idx;
   logic                 lat_jtag;
   logic [NUM_LANES-1:0] shift_en_q;
   logic                 jtag_q;
   logic                 gate_q;
   logic                 busy_q;
   logic                 ack_q;
   logic                 err_q;
   logic [NUM_LANES-1:0] req_therm;
   logic [NUM_LANES-1:0] lat_therm;
   logic                 idx_bad;
   logic                 no_change;

   // Incoming index decoded for the no-change compare in IDLE.
   aibnd_red_therm_dec #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_dec_req (
      .idx   (bus.cfg_fail_idx),
      .therm (req_therm)
   );

   // Latched index decoded for the pattern driven at APPLY.
   aibnd_red_therm_dec #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_dec_lat (
      .idx   (lat_idx),
      .therm (lat_therm)
   );

   assign idx_bad   = (bus.cfg_fail_idx > IDX_W'(NUM_LANES));
   assign no_change = (req_therm == shift_en_q) && (bus.cfg_jtag_sel == jtag_q);

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat_idx    <= '0;
         lat_jtag   <= 1'b0;
         shift_en_q <= '0;
         jtag_q     <= 1'b0;
         gate_q     <= 1'b0;
         busy_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.cfg_req) begin
                  lat_idx  <= bus.cfg_fail_idx;
                  lat_jtag <= bus.cfg_jtag_sel;
                  busy_q   <= 1'b1;
                  if (idx_bad) begin
                     err_q <= 1'b1;
                     ack_q <= 1'b1;
                     state <= ST_ACK;
                  end else if (no_change) begin
                     ack_q <= 1'b1;
                     state <= ST_ACK;
                  end else begin
                     gate_q <= 1'b1;
                     cnt    <= CNT_LOAD;
                     state  <= ST_GATE;
                  end
               end
            end
            ST_GATE: begin
               // Selects move on entry to APPLY, after SETTLE_CYC gated cycles.
               if (cnt == '0) begin
                  shift_en_q <= lat_therm;
                  jtag_q     <= lat_jtag;
                  state      <= ST_APPLY;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_APPLY: begin
               cnt   <= CNT_LOAD;
               state <= ST_RELEASE;
            end
            ST_RELEASE: begin
               if (cnt == '0) begin
                  gate_q <= 1'b0;
                  ack_q  <= 1'b1;
                  state  <= ST_ACK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ACK: begin
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef AIBND_RED_REPAIR_CNT_EN
   logic [RED_CNT_W-1:0] rep_cnt_q;

   // Saturating count of APPLY cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rep_cnt_q <= '0;
      else if (state == ST_APPLY && rep_cnt_q != {RED_CNT_W{1'b1}})
         rep_cnt_q <= rep_cnt_q + 1'b1;
   end

   assign bus.repair_cnt = rep_cnt_q;
`else
   assign bus.repair_cnt = '0;
`endif

   assign bus.shift_en    = shift_en_q;
   assign bus.jtag_clksel = jtag_q;
   assign bus.mux_gate    = gate_q;
   assign bus.busy        = busy_q;
   assign bus.cfg_ack     = ack_q;
   assign bus.err         = err_q;

endmodule

// File: doc/aibnd_red_shift_seq.md
# aibnd_red_shift_seq

Parametrised redundancy-shift sequencer for an AIB IO column. It drives the `shift_en` selects of NUM_LANES per-lane redundancy clock/data muxes and the JTAG clock select. On each reconfiguration it gates the muxes, lets them settle, applies the new select pattern and releases the gate, so lane repair is glitch-free at runtime. It is the sequential successor to the static per-lane `shift_en`/`jtag_clksel` mux wiring and sits between the repair/configuration registers and the lane mux array.

## Interface
Parameters:
- NUM_LANES, 16, number of lane muxes driven; must be ≥2.
- SETTLE_CYC, 4, gate-to-apply and apply-to-release wait in cycles; must be ≥1.
- IDX_W, $clog2(NUM_LANES+1), derived width of the lane index; not to be overridden.

Ports:
- clk  in  1  sequencer clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_req  in  1  configuration request; sampled only in IDLE.
- cfg_fail_idx  in  IDX_W  index of the failed lane; NUM_LANES means no repair.
- cfg_jtag_sel  in  1  requested JTAG clock select.
- cfg_ack  out  1  one-cycle pulse when the request completes.
- busy  out  1  high in every state except IDLE.
- mux_gate  out  1  high while the lane muxes must hold or gate their clocks.
- shift_en  out  NUM_LANES  thermometer pattern: bit i = 1 when i ≥ applied fail index.
- jtag_clksel  out  1  applied JTAG clock select.
- err  out  1  sticky flag for an invalid index.
- repair_cnt  out  8  count of applied changes (see Configuration).

## Operation
States: IDLE, GATE, APPLY, RELEASE, ACK.

- **IDLE**
  - `cfg_req`=1 latches `cfg_fail_idx` and `cfg_jtag_sel`.
  - If the index is > NUM_LANES: set `err`, go to ACK, no gating, outputs unchanged.
  - Else if the new thermometer pattern and jtag select equal the applied ones: go to ACK with no gating.
  - Else: go to GATE and load the settle counter with SETTLE_CYC−1.
- **GATE**
  - `mux_gate`=1; the counter decrements each cycle.
  - At 0, go to APPLY.
- **APPLY** (one cycle)
  - `shift_en` and `jtag_clksel` registers take the new values on entry.
  - Reload the counter and go to RELEASE.
- **RELEASE**
  - `mux_gate` stays 1; the counter counts down.
  - At 0, go to ACK.
- **ACK** (one cycle)
  - `cfg_ack`=1 and `mux_gate`=0.
  - Return to IDLE.

Handshake rules:
- `cfg_req` is ignored while `busy`=1. It is not queued.
- If `cfg_req` is still high in the IDLE cycle after ACK, it starts a new transaction. The requester must drop `cfg_req` upon seeing `cfg_ack`.
- Index arithmetic: thermometer bit i = (i ≥ idx), compared unsigned at IDX_W bits. Index 0 gives all ones; index NUM_LANES gives all zeros.
- `err` clears only on `rst`.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values:
  - `shift_en`=0, `jtag_clksel`=0, `mux_gate`=0, `busy`=0, `cfg_ack`=0, `err`=0, `repair_cnt`=0.
  - State is IDLE.
- Reset asserted mid-transaction discards the latched request and forces the reset values on the next edge of `rst`, independent of `clk`.
- With `req` seen in IDLE at edge T (S = SETTLE_CYC):
  - `busy`=`mux_gate`=1 from T+1.
  - `shift_en` changes at T+S+1.
  - `cfg_ack`=1 and `mux_gate`=0 at T+2S+2.
  - IDLE at T+2S+3.
- No-change or invalid request: `busy`=`cfg_ack`=1 at T+1 only. `err` also rises at T+1 when the index is invalid.
- `shift_en` and `jtag_clksel` change only while `mux_gate`=1, with at least S gated cycles on each side of the change.

## Configuration
- `AIBND_RED_REPAIR_CNT_EN` defined:
  - `repair_cnt` increments by 1 in each APPLY cycle.
  - It saturates at 255.
  - It resets to 0.
- Not defined: `repair_cnt` is tied to 0 and no counter logic is built.

## Structure
- Package `aibnd_red_pkg`:
  - State enum typedef (`red_state_t`).
  - Constant `RED_CNT_W`=8.
  - Helper function computing IDX_W.
- Sub-module `aibnd_red_therm_dec`:
  - Combinational, parametrised by NUM_LANES.
  - Maps an index to the NUM_LANES-bit thermometer pattern.
  - Used both for the applied pattern and for the no-change compare.

## Test plan
- **Reset:** assert `rst` asynchronously mid-RELEASE with NUM_LANES=16, S=4 → all outputs at their reset values before the next `clk`; state IDLE.
- **Basic repair:** req with idx=5, jtag=0 at T → `mux_gate` high T+1..T+9, `shift_en`=16'hFFE0 at T+5, `cfg_ack` pulse at T+10, `busy` low at T+11.
- **No-change:** repeat idx=5 → `cfg_ack` at T+1, `mux_gate` never asserts, `repair_cnt` unchanged.
- **Invalid:** idx=17 → `err`=1 and `cfg_ack` at T+1, `shift_en` unchanged. A following valid req still completes and `err` stays 1.
- **Boundaries:** idx=0 gives 16'hFFFF and idx=16 gives 16'h0000. A req pulsed during GATE is ignored (exactly one `cfg_ack`). jtag toggle only with the same idx triggers a full gated sequence.
- **Counter (macro on):** 300 alternating idx 3/4 requests → `repair_cnt`=255 saturated. Macro off → `repair_cnt`=0 throughout.
